// File: rtl/ir_nec_rx_param_if.sv
`default_nettype none
// ============================================================================
// Module   : ir_nec_rx_param_if
// Brief    : Result handshake bundle between the NEC decoder and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface ir_nec_rx_param_if;
  logic [31:0] out_data;
  logic        out_repeat;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_repeat,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_repeat,
    input  out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/ir_nec_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : ir_nec_rx_param
// Brief    : NEC IR frame / repeat decoder with microsecond width measurement,
//            selectable integrity check and a single-entry valid/ready output.
//            Optional input glitch filter: define IR_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ir_nec_rx_param #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int ACTIVE_LOW    = 1,
  parameter int CHECK_MODE    = 1,
  parameter int TOL_PCT       = 25,
  parameter int TIMEOUT_US    = 12000,
  parameter int GLITCH_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_in,
  ir_nec_rx_param_if.master out_if,
  output logic              err,
  output logic              overflow,
  output logic              busy
);

  function automatic logic [15:0] win_lo(input int nom);
    return 16'(nom - (nom * TOL_PCT) / 100);
  endfunction

  function automatic logic [15:0] win_hi(input int nom);
    return 16'(nom + (nom * TOL_PCT) / 100);
  endfunction

  function automatic logic in_win(input logic [15:0] w, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  function automatic logic check_ok(input logic [31:0] d);
    logic ok;
    ok = 1'b1;
    if ((CHECK_MODE >= 1) && (d[31:24] != ~d[23:16])) ok = 1'b0;
    if ((CHECK_MODE >= 2) && (d[15:8] != ~d[7:0]))    ok = 1'b0;
    return ok;
  endfunction

  localparam int              c_div        = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int              c_pw         = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_pw-1:0] c_presc_last = c_pw'(c_div - 1);
  localparam logic            c_idle_raw   = (ACTIVE_LOW != 0);
  localparam logic [15:0]     c_timeout    = 16'(TIMEOUT_US);

  localparam logic [15:0] c_lead_lo = win_lo(9000);
  localparam logic [15:0] c_lead_hi = win_hi(9000);
  localparam logic [15:0] c_data_lo = win_lo(4500);
  localparam logic [15:0] c_data_hi = win_hi(4500);
  localparam logic [15:0] c_rpt_lo  = win_lo(2250);
  localparam logic [15:0] c_rpt_hi  = win_hi(2250);
  localparam logic [15:0] c_bit_lo  = win_lo(560);
  localparam logic [15:0] c_bit_hi  = win_hi(560);
  localparam logic [15:0] c_one_lo  = win_lo(1690);
  localparam logic [15:0] c_one_hi  = win_hi(1690);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_RPT_MARK   = 3'd5
  } state_t;

  // ---------------------------------------------------------------- input path
  logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic w_norm, w_level, w_rise, w_fall, w_edge;

  assign w_norm = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

`ifdef IR_GLITCH_FILTER_EN
  localparam int              c_gw          = $clog2(GLITCH_CYCLES + 1);
  localparam logic [c_gw-1:0] c_glitch_last = c_gw'(GLITCH_CYCLES - 1);

  logic            filt_q, filt_d;
  logic [c_gw-1:0] gcnt_q, gcnt_d;

  // A new level is adopted only on its GLITCH_CYCLES-th consecutive sample.
  always_comb begin
    filt_d = filt_q;
    gcnt_d = '0;
    if (w_norm != filt_q) begin
      if (gcnt_q == c_glitch_last) begin
        filt_d = w_norm;
      end else begin
        gcnt_d = gcnt_q + c_gw'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      gcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      gcnt_q <= gcnt_d;
    end
  end

  assign w_level = filt_q;
`else
  localparam int c_unused_glitch_cycles = GLITCH_CYCLES;
  assign w_level = w_norm;
`endif

  assign w_rise = w_level & ~prev_q;
  assign w_fall = ~w_level & prev_q;
  assign w_edge = w_rise | w_fall;

  always_comb begin
    sync1_d = ir_in;
    sync2_d = sync1_q;
    prev_d  = w_level;
  end

  // ------------------------------------------------------------ width counter
  logic [c_pw-1:0] presc_q, presc_d;
  logic [15:0]     cnt_q, cnt_d;

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (w_edge) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (presc_q == c_presc_last) begin
      presc_d = '0;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else begin
      presc_d = presc_q + c_pw'(1);
    end
  end

  logic w_in_lead, w_in_data, w_in_rpt, w_in_bit, w_in_one, w_timeout;
  assign w_in_lead = in_win(cnt_q, c_lead_lo, c_lead_hi);
  assign w_in_data = in_win(cnt_q, c_data_lo, c_data_hi);
  assign w_in_rpt  = in_win(cnt_q, c_rpt_lo, c_rpt_hi);
  assign w_in_bit  = in_win(cnt_q, c_bit_lo, c_bit_hi);
  assign w_in_one  = in_win(cnt_q, c_one_lo, c_one_hi);

  // ---------------------------------------------------------------------- FSM
  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] last_q, last_d;
  logic        seen_q, seen_d;
  logic [31:0] w_shift_ins;
  logic        w_abort, w_res_valid, w_res_rpt, w_err_ev;
  logic [31:0] w_res_data;

  assign w_timeout = (state_q != S_IDLE) && (cnt_q >= c_timeout);

  always_comb begin
    w_shift_ins         = shift_q;
    w_shift_ins[idx_q]  = w_in_one;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    last_d      = last_q;
    seen_d      = seen_q;
    w_abort     = 1'b0;
    w_res_valid = 1'b0;
    w_res_data  = shift_q;
    w_res_rpt   = 1'b0;
    w_err_ev    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_rise) state_d = S_LEAD_MARK;
      end
      S_LEAD_MARK: begin
        if (w_fall) begin
          if (w_in_lead) state_d = S_LEAD_SPACE;
          else           w_abort = 1'b1;
        end
      end
      S_LEAD_SPACE: begin
        if (w_rise) begin
          if (w_in_data) begin
            state_d = S_BIT_MARK;
            idx_d   = '0;
            shift_d = '0;
          end else if (w_in_rpt) begin
            state_d = S_RPT_MARK;
          end else begin
            w_abort = 1'b1;
          end
        end
      end
      S_BIT_MARK: begin
        if (w_fall) begin
          if (w_in_bit) state_d = S_BIT_SPACE;
          else          w_abort = 1'b1;
        end
      end
      S_BIT_SPACE: begin
        if (w_rise) begin
          if (w_in_bit || w_in_one) begin
            shift_d = w_shift_ins;
            // The stop mark after bit 31 is never measured; its leading edge ends the frame.
            if (idx_q == 5'd31) begin
              state_d = S_IDLE;
              if (check_ok(w_shift_ins)) begin
                w_res_valid = 1'b1;
                w_res_data  = w_shift_ins;
                last_d      = w_shift_ins;
                seen_d      = 1'b1;
              end else begin
                w_err_ev = 1'b1;
              end
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = S_BIT_MARK;
            end
          end else begin
            w_abort = 1'b1;
          end
        end
      end
      S_RPT_MARK: begin
        if (w_fall) begin
          if (w_in_bit) begin
            state_d = S_IDLE;
            if (seen_q) begin
              w_res_valid = 1'b1;
              w_res_data  = last_q;
              w_res_rpt   = 1'b1;
            end else begin
              w_err_ev = 1'b1;
            end
          end else begin
            w_abort = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_abort || w_timeout) begin
      state_d     = S_IDLE;
      shift_d     = '0;
      idx_d       = idx_q;
      last_d      = last_q;
      seen_d      = seen_q;
      w_res_valid = 1'b0;
      w_res_rpt   = 1'b0;
      w_err_ev    = 1'b1;
    end
  end

  // ------------------------------------------------------------- output stage
  logic [31:0] out_data_q, out_data_d;
  logic        out_repeat_q, out_repeat_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d, ovf_q, ovf_d;

  always_comb begin
    out_data_d   = out_data_q;
    out_repeat_d = out_repeat_q;
    out_valid_d  = out_valid_q;
    err_d        = w_err_ev;
    ovf_d        = 1'b0;
    if (out_valid_q && out_if.out_ready) out_valid_d = 1'b0;
    // A handshake in the same cycle frees the slot for the incoming result.
    if (w_res_valid) begin
      if (!out_valid_q || out_if.out_ready) begin
        out_data_d   = w_res_data;
        out_repeat_d = w_res_rpt;
        out_valid_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= c_idle_raw;
      sync2_q      <= c_idle_raw;
      prev_q       <= 1'b0;
      presc_q      <= '0;
      cnt_q        <= '0;
      state_q      <= S_IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      last_q       <= '0;
      seen_q       <= 1'b0;
      out_data_q   <= '0;
      out_repeat_q <= 1'b0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      seen_q       <= seen_d;
      out_data_q   <= out_data_d;
      out_repeat_q <= out_repeat_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_if.out_data   = out_data_q;
  assign out_if.out_repeat = out_repeat_q;
  assign out_if.out_valid  = out_valid_q;
  assign err               = err_q;
  assign overflow          = ovf_q;
  assign busy              = (state_q != S_IDLE);

endmodule
`default_nettype wire
